adder_feeder: RTL and testbench

Operand issue and result collection stage wrapped around the 4-bit registered adder. Upstream logic hands operand pairs over a valid/ready port. The block buffers them in a small FIFO and drives the adder's A/B/En inputs. It then captures Sum/Overflow one cycle after each enable and returns results in order over a second valid/ready port. Full throughput is one result per cycle when the consumer keeps Out_Ready high.

---
 rtl/adder_feeder.sv | 133 +++++++++++++
 tb/tb_adder_feeder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_feeder.sv
// Operand FIFO and result collector for a registered WIDTH-bit adder.
// Define ADDER_FEEDER_OVF_SAT_EN to saturate Out_Sum to all-ones on carry-out.
module adder_feeder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_A,
  input  logic [WIDTH-1:0] In_B,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             En,
  input  logic [WIDTH-1:0] Sum,
  input  logic             Overflow,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out_Sum,
  output logic             Out_Overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] fifo_a [DEPTH];
  logic [WIDTH-1:0] fifo_b [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    fifo_cnt;

  logic             v2;
  logic [WIDTH:0]   res_mem [3];
  logic [1:0]       res_wr;
  logic [1:0]       res_rd;
  logic [1:0]       res_cnt;
  logic [WIDTH:0]   head;

  logic             push;
  logic             issue;
  logic             drain;
  logic [2:0]       used;

  function automatic logic [1:0] res_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign In_Ready  = (fifo_cnt != FULL_CNT);
  assign push      = In_Valid && In_Ready;
  assign Out_Valid = (res_cnt != 2'd0);
  assign drain     = Out_Valid && Out_Ready;

  // Credits: En stage, adder register stage and buffered results share 3 slots.
  assign used  = {2'b00, En} + {2'b00, v2} + {1'b0, res_cnt} - {2'b00, drain};
  assign issue = (fifo_cnt != '0) && (used < 3'd3);

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= In_A;
      fifo_b[wr_ptr] <= In_B;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (issue)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      A  <= '0;
      B  <= '0;
      En <= 1'b0;
      v2 <= 1'b0;
    end else begin
      En <= issue;
      v2 <= En;
      if (issue) begin
        A <= fifo_a[rd_ptr];
        B <= fifo_b[rd_ptr];
      end
    end
  end

  // Storage needs no reset: the outputs are forced to zero whenever the buffer is empty.
  always_ff @(posedge Clk) begin
    if (v2)
      res_mem[res_wr] <= {Overflow, Sum};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      res_wr  <= 2'd0;
      res_rd  <= 2'd0;
      res_cnt <= 2'd0;
    end else begin
      if (v2)
        res_wr <= res_next(res_wr);
      if (drain)
        res_rd <= res_next(res_rd);
      case ({v2, drain})
        2'b10:   res_cnt <= res_cnt + 2'd1;
        2'b01:   res_cnt <= res_cnt - 2'd1;
        default: res_cnt <= res_cnt;
      endcase
    end
  end

  assign head         = res_mem[res_rd];
  assign Out_Overflow = Out_Valid && head[WIDTH];

`ifdef ADDER_FEEDER_OVF_SAT_EN
  assign Out_Sum = !Out_Valid ? '0 : (head[WIDTH] ? '1 : head[WIDTH-1:0]);
`else
  assign Out_Sum = Out_Valid ? head[WIDTH-1:0] : '0;
`endif

endmodule

// File: tb/tb_adder_feeder.sv
// Directed bench for adder_feeder with a behavioural registered adder model.
// Honours ADDER_FEEDER_OVF_SAT_EN when computing expected sums.
module tb_adder_feeder;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             en;
  logic [WIDTH-1:0] sum;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_overflow;

  int total = 0;
  int bad   = 0;
  int issued = 0;
  int popped = 0;
  int rcvd   = 0;
  bit sb_en  = 1'b0;
  logic [WIDTH:0] exp_q [$];

  adder_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(clk), .Rst_n(rst_n),
    .In_Valid(in_valid), .In_Ready(in_ready), .In_A(in_a), .In_B(in_b),
    .A(a), .B(b), .En(en), .Sum(sum), .Overflow(overflow),
    .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Out_Sum(out_sum), .Out_Overflow(out_overflow)
  );

  always #5 clk = ~clk;

  // Registered adder: samples on En, never reset.
  always @(posedge clk)
    if (en) {overflow, sum} <= {1'b0, a} + {1'b0, b};

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
`ifdef ADDER_FEEDER_OVF_SAT_EN
    if (s[WIDTH]) s[WIDTH-1:0] = '1;
`endif
    return s;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_in_ready"}, 32'(in_ready), 1);
    check_output({tag, "_en"}, 32'(en), 0);
    check_output({tag, "_a"}, 32'(a), 0);
    check_output({tag, "_b"}, 32'(b), 0);
    check_output({tag, "_out_valid"}, 32'(out_valid), 0);
    check_output({tag, "_out_sum"}, 32'(out_sum), 0);
    check_output({tag, "_out_ovf"}, 32'(out_overflow), 0);
  endtask

  // In-flight plus buffered results may never exceed the 3 result slots.
  always @(negedge clk) begin
    if (!rst_n) begin
      issued = 0;
      popped = 0;
    end else begin
      if (en) issued++;
      check_output("credit_limit", 32'(issued - popped <= 3), 1);
      if (out_valid && out_ready) popped++;
    end
  end

  always @(negedge clk) begin
    if (sb_en && rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_output("sb_unexpected_result", 32'(exp_q.size()), 1);
      end else begin
        check_output("sb_result", 32'({out_overflow, out_sum}), 32'(exp_q.pop_front()));
      end
      rcvd++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int got;
    int sent;
    int cyc;
    bit rdy;
    logic [WIDTH:0] e;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #12;
    check_reset_values("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Single pair 3+4.
    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd4;
    tick();
    in_valid = 1'b0;
    check_output("t1_en_k", 32'(en), 0);
    tick();
    check_output("t1_en_k1", 32'(en), 1);
    check_output("t1_a", 32'(a), 3);
    check_output("t1_b", 32'(b), 4);
    tick();
    check_output("t1_en_k2", 32'(en), 0);
    check_output("t1_valid_k2", 32'(out_valid), 0);
    tick();
    check_output("t1_valid_k3", 32'(out_valid), 1);
    check_output("t1_sum", 32'(out_sum), 7);
    check_output("t1_ovf", 32'(out_overflow), 0);
    tick();
    check_output("t1_valid_after", 32'(out_valid), 0);

    // Carry-out 9+8.
    in_valid = 1'b1; in_a = 4'd9; in_b = 4'd8;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check_output("t2_valid", 32'(out_valid), 1);
`ifdef ADDER_FEEDER_OVF_SAT_EN
    check_output("t2_sum", 32'(out_sum), 15);
`else
    check_output("t2_sum", 32'(out_sum), 1);
`endif
    check_output("t2_ovf", 32'(out_overflow), 1);
    tick();

    // Stream (i, i+1): results 1,3,...,15 on consecutive cycles.
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_a = 4'(c); in_b = 4'(c + 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check_output("t3_in_ready", 32'(in_ready), 1);
      if (c >= 3 && c <= 10) begin
        check_output("t3_valid", 32'(out_valid), 1);
        check_output("t3_sum", 32'(out_sum), 32'(2 * (c - 3) + 1));
      end
      if (c == 11)
        check_output("t3_valid_end", 32'(out_valid), 0);
    end

    // Backpressure: pairs (j, 3) with Out_Ready low.
    out_ready = 1'b0; acc = 0;
    in_valid = 1'b1; in_a = 4'd0; in_b = 4'd3;
    for (int c = 0; c < 12; c++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        acc++;
        in_a = 4'(acc);
      end
    end
    check_output("t4_accepted", 32'(acc), 7);
    check_output("t4_in_ready_low", 32'(in_ready), 0);
    check_output("t4_head_valid", 32'(out_valid), 1);
    check_output("t4_head_sum", 32'(out_sum), 3);
    tick();
    check_output("t4_head_stable", 32'(out_sum), 3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) begin
        check_output("t4_drain_sum", 32'(out_sum), 32'(got + 3));
        got++;
      end
      tick();
    end
    check_output("t4_drained", 32'(got), 7);
    check_output("t4_in_ready_back", 32'(in_ready), 1);
    check_output("t4_empty", 32'(out_valid), 0);

    // Reset with two pairs queued and one in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 4'd1; in_b = 4'd1;
    for (int c = 0; c < 5; c++) tick();
    in_valid = 1'b0;
    check_output("t5_pre_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("t5_async");
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check_output("t5_no_valid", 32'(out_valid), 0);
      check_output("t5_no_en", 32'(en), 0);
    end

    // Random pairs through a full FIFO, checked by scoreboard.
    sb_en = 1'b1; rcvd = 0; sent = 0; cyc = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 4'($urandom); in_b = 4'($urandom);
    while (sent < 50 && cyc < 1000) begin
      out_ready = (cyc >= 8);
      rdy = in_ready;
      tick();
      cyc++;
      if (rdy) begin
        e = model(in_a, in_b);
        exp_q.push_back(e);
        sent++;
        in_a = 4'($urandom);
        in_b = 4'($urandom);
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
    tick();
    check_output("t6_sent", 32'(sent), 50);
    check_output("t6_received", 32'(rcvd), 50);
    check_output("t6_queue_empty", 32'(exp_q.size()), 0);
    check_output("t6_in_ready", 32'(in_ready), 1);
    sb_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
